// File: rtl/alu_pkg.sv
// Shared definitions for the Hack ALU self-test sequencer: op codes, table size, FSM states.
// Op bit order is {no, f, ny, zy, nx, zx}, i.e. op[0]=zx ... op[5]=no.
package alu_pkg;

  localparam int TABLE_SIZE = 18;

  localparam logic [5:0] OP_ZERO  = 6'b010101;
  localparam logic [5:0] OP_ONE   = 6'b111111;
  localparam logic [5:0] OP_NEG1  = 6'b010111;
  localparam logic [5:0] OP_X     = 6'b001100;
  localparam logic [5:0] OP_Y     = 6'b000011;
  localparam logic [5:0] OP_NOTX  = 6'b101100;
  localparam logic [5:0] OP_NOTY  = 6'b100011;
  localparam logic [5:0] OP_NEGX  = 6'b111100;
  localparam logic [5:0] OP_NEGY  = 6'b110011;
  localparam logic [5:0] OP_XP1   = 6'b111110;
  localparam logic [5:0] OP_YP1   = 6'b111011;
  localparam logic [5:0] OP_XM1   = 6'b011100;
  localparam logic [5:0] OP_YM1   = 6'b010011;
  localparam logic [5:0] OP_ADD   = 6'b010000;
  localparam logic [5:0] OP_XSUBY = 6'b110010;
  localparam logic [5:0] OP_YSUBX = 6'b111000;
  localparam logic [5:0] OP_AND   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic logic [5:0] op_code(input int unsigned i);
    case (i)
      0:       return OP_ZERO;
      1:       return OP_ONE;
      2:       return OP_NEG1;
      3:       return OP_X;
      4:       return OP_Y;
      5:       return OP_NOTX;
      6:       return OP_NOTY;
      7:       return OP_NEGX;
      8:       return OP_NEGY;
      9:       return OP_XP1;
      10:      return OP_YP1;
      11:      return OP_XM1;
      12:      return OP_YM1;
      13:      return OP_ADD;
      14:      return OP_XSUBY;
      15:      return OP_YSUBX;
      16:      return OP_AND;
      17:      return OP_OR;
      default: return OP_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/alu_ref.sv
// Combinational Hack ALU reference used as the expected-value model by alu_seq.
module alu_ref #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z    = op[0] ? '0 : x;
    x_n    = op[1] ? ~x_z : x_z;
    y_z    = op[2] ? '0 : y;
    y_n    = op[3] ? ~y_z : y_z;
    f_out  = op[4] ? (x_n + y_n) : (x_n & y_n);
    result = op[5] ? ~f_out : f_out;
  end

  assign zr = (result == '0);
  assign ng = result[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Sequencer that sweeps all 18 Hack ALU ops against an external ALU and tallies mismatches.
// Define ALU_SEQ_HALT_EN to stop the sweep at the first mismatch.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [5:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             zr,
  input  logic             ng,
  output logic             busy,
  output logic             done,
  output logic [4:0]       pass_cnt,
  output logic [4:0]       fail_cnt,
  output logic [4:0]       first_fail,
  output logic             fail_seen
);

  localparam logic [4:0] LAST_IDX = 5'(TABLE_SIZE - 1);

  state_t           state_reg;
  logic [4:0]       idx_reg;
  logic [WIDTH-1:0] a_reg, b_reg, x_reg, y_reg;
  logic [5:0]       op_reg;
  logic             busy_reg, done_reg, fail_seen_reg;
  logic [4:0]       pass_reg, fail_reg, first_fail_reg;

  logic [5:0]       op_rom [TABLE_SIZE];
  logic [WIDTH-1:0] exp_result;
  logic             exp_zr, exp_ng, match, last_op;

  for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_rom
    assign op_rom[gi] = op_code(gi);
  end

  alu_ref #(.WIDTH(WIDTH)) u_ref (
    .x      (x_reg),
    .y      (y_reg),
    .op     (op_reg),
    .result (exp_result),
    .zr     (exp_zr),
    .ng     (exp_ng)
  );

  assign match = (result == exp_result) && (zr == exp_zr) && (ng == exp_ng);

`ifdef ALU_SEQ_HALT_EN
  assign last_op = (idx_reg == LAST_IDX) || (!match && !fail_seen_reg);
`else
  assign last_op = (idx_reg == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      op_reg         <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      pass_reg       <= '0;
      fail_reg       <= '0;
      first_fail_reg <= '0;
      fail_seen_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_reg          <= a_in;
            b_reg          <= b_in;
            idx_reg        <= '0;
            pass_reg       <= '0;
            fail_reg       <= '0;
            first_fail_reg <= '0;
            fail_seen_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
            state_reg      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          x_reg     <= a_reg;
          y_reg     <= b_reg;
          op_reg    <= op_rom[idx_reg];
          state_reg <= ST_CHECK;
        end
        ST_CHECK: begin
          if (match) begin
            pass_reg <= pass_reg + 5'd1;
          end else begin
            fail_reg <= fail_reg + 5'd1;
            if (!fail_seen_reg) begin
              first_fail_reg <= idx_reg;
              fail_seen_reg  <= 1'b1;
            end
          end
          if (last_op) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            idx_reg   <= idx_reg + 5'd1;
            state_reg <= ST_DRIVE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign op         = op_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign pass_cnt   = pass_reg;
  assign fail_cnt   = fail_reg;
  assign first_fail = first_fail_reg;
  assign fail_seen  = fail_seen_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a faultable behavioural ALU plus a per-sweep model of the expected tallies.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic [15:0] x, y, result;
  logic [5:0]  op;
  logic        zr, ng, busy, done, fail_seen;
  logic [4:0]  pass_cnt, fail_cnt, first_fail;

  int          n_checks = 0;
  int          n_fail = 0;
  int          fault_mode = 0;
  logic [17:0] fault_mask = '0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .x(x), .y(y), .op(op), .result(result), .zr(zr), .ng(ng),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .first_fail(first_fail), .fail_seen(fail_seen)
  );

  // Table rows as written: zx nx zy ny f no (leftmost = zx).
  function automatic logic [5:0] spec_str(input int i);
    case (i)
      0: return 6'b101010;  1: return 6'b111111;  2: return 6'b111010;
      3: return 6'b001100;  4: return 6'b110000;  5: return 6'b001101;
      6: return 6'b110001;  7: return 6'b001111;  8: return 6'b110011;
      9: return 6'b011111; 10: return 6'b110111; 11: return 6'b001110;
      12: return 6'b110010; 13: return 6'b000010; 14: return 6'b010011;
      15: return 6'b000111; 16: return 6'b000000; 17: return 6'b010101;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] to_op(input logic [5:0] s);
    logic [5:0] o;
    for (int j = 0; j < 6; j++) o[j] = s[5-j];
    return o;
  endfunction

  function automatic int decode_idx(input logic [5:0] o);
    for (int i = 0; i < 18; i++)
      if (to_op(spec_str(i)) == o) return i;
    return -1;
  endfunction

  function automatic logic [15:0] sem(input int i, input logic [15:0] a, input logic [15:0] b);
    case (i)
      0: return 16'd0;      1: return 16'd1;      2: return 16'hFFFF;
      3: return a;          4: return b;          5: return ~a;
      6: return ~b;         7: return 16'd0 - a;  8: return 16'd0 - b;
      9: return a + 16'd1; 10: return b + 16'd1; 11: return a - 16'd1;
      12: return b - 16'd1; 13: return a + b;     14: return a - b;
      15: return b - a;     16: return a & b;     17: return a | b;
      default: return 16'd0;
    endcase
  endfunction

  // Faulty ALU output for op i: 1 = zr stuck 0, 2 = result bit0 stuck 1, 3 = flip bit0 on masked ops.
  task automatic faulty(input int i, input logic [15:0] v, input int m, input logic [17:0] msk,
                        output logic [15:0] r, output logic z, output logic n);
    r = v; z = (v == 16'd0); n = v[15];
    if (m == 1) z = 1'b0;
    else if (m == 2) r = v | 16'd1;
    else if (m == 3 && i >= 0 && msk[i]) r = v ^ 16'd1;
  endtask

  int          alu_k;
  logic [15:0] alu_v;
  always_comb begin
    alu_k = decode_idx(op);
    alu_v = (alu_k >= 0) ? sem(alu_k, x, y) : 16'd0;
    faulty(alu_k, alu_v, fault_mode, fault_mask, result, zr, ng);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [15:0] b, input int m, input logic [17:0] msk,
                       output int ep, output int ef, output int efirst, output int eseen, output int ncyc);
    logic [15:0] v, r;
    logic z, n;
    bit bad;
    ep = 0; ef = 0; efirst = 0; eseen = 0; ncyc = 36;
    for (int i = 0; i < 18; i++) begin
      v = sem(i, a, b);
      faulty(i, v, m, msk, r, z, n);
      bad = (r != v) || (z != (v == 16'd0)) || (n != v[15]);
      if (bad) begin
        ef++;
        if (eseen == 0) begin efirst = i; eseen = 1; end
      end else ep++;
`ifdef ALU_SEQ_HALT_EN
      if (bad && ef == 1) begin ncyc = 2 * (i + 1); break; end
`endif
    end
  endtask

  task automatic run_sweep(input logic [15:0] a, input logic [15:0] b, input int m,
                           input logic [17:0] msk, input int restart_at);
    int ep, ef, efirst, eseen, ncyc;
    model(a, b, m, msk, ep, ef, efirst, eseen, ncyc);
    @(negedge clk);
    fault_mode = m; fault_mask = msk;
    a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int n = 1; n <= ncyc; n++) begin
      if (n == restart_at) begin start = 1'b1; a_in = ~a; b_in = ~b; end
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (n < ncyc) begin
        check("busy_mid", busy, 1);
        check("done_early", done, 0);
        if (n % 2 == 1) begin
          check($sformatf("op_idx%0d", (n - 1) / 2), op, to_op(spec_str((n - 1) / 2)));
          check("x_drive", x, a);
          check("y_drive", y, b);
        end
      end else begin
        check("done_end", done, 1);
        check("busy_end", busy, 0);
        check("pass_cnt", pass_cnt, ep);
        check("fail_cnt", fail_cnt, ef);
        check("first_fail", first_fail, efirst);
        check("fail_seen", fail_seen, eseen);
        check("x_hold", x, a);
      end
    end
    $display("sweep a=%04h b=%04h mode=%0d mask=%05h: pass=%0d fail=%0d first=%0d seen=%0d cycles=%0d",
             a, b, m, msk, pass_cnt, fail_cnt, first_fail, fail_seen, ncyc);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_op"}, op, 0);
    check({tag, "_pass"}, pass_cnt, 0);
    check({tag, "_fail"}, fail_cnt, 0);
    check({tag, "_first"}, first_fail, 0);
    check({tag, "_seen"}, fail_seen, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_sweep(16'd2, 16'd3, 0, '0, 0);
    run_sweep(16'd0, 16'd0, 0, '0, 0);
    run_sweep(16'd2, 16'd3, 1, '0, 0);
    run_sweep(16'h7FFF, 16'd1, 0, '0, 0);
    run_sweep(16'd2, 16'd3, 2, '0, 0);
    run_sweep(16'h1234, 16'h00F0, 3, 18'h00420, 7);
    for (int r = 0; r < 10; r++) begin
      run_sweep(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                18'($urandom & $urandom & $urandom), int'($urandom_range(0, 20)));
    end

    // Reset ten cycles into a sweep.
    @(negedge clk);
    fault_mode = 0; a_in = 16'd5; b_in = 16'd9; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_state("midrst");
    $display("mid-sweep reset: busy=%0d op=%02h pass=%0d", busy, op, pass_cnt);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_reset_state("rst_start");
    @(posedge clk); @(negedge clk);
    check("idle_stays_busy", busy, 0);
    check("idle_stays_done", done, 0);
    $display("rst+start: busy=%0d done=%0d", busy, done);

    run_sweep(16'hFFFF, 16'h8000, 0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
